// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser states, oversampling ratio and the
// default frame width used by the transmit path.
package uart_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO in front of the UART serialiser. Full/empty come from the
// registered occupancy count, so a push while full is always dropped even if
// a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser driven by the
// shared 16x-baud tick. The line output and status flags are registered.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int STOP_TICKS = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr,
    output logic                 full,
    output logic                 busy,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int BIT_W = $clog2(DATA_BITS) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0]       LAST_TICK = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]       STOP_LAST = 5'(STOP_TICKS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [4:0]           tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 busy_q, busy_d;
    logic                 fifo_pop_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic [CNT_W-1:0]     fifo_count_s;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr),
        .pop_i   (fifo_pop_s),
        .din_i   (din),
        .dout_o  (fifo_dout_s),
        .full_o  (full),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign tx      = tx_q;
    assign tx_done = tx_done_q;
    assign busy    = busy_q;

    // Serialiser next-state logic; counters only advance on tick.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        fifo_pop_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_d    = fifo_dout_s;
                    tx_d       = 1'b0;
                    tick_cnt_d = 5'd0;
                    bit_cnt_d  = {BIT_W{1'b0}};
                    state_d    = START;
                end else begin
                    tx_d = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = 5'd0;
                        tx_d       = shift_q[0];
                        state_d    = DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = 5'd0;
                        shift_d    = shift_q >> 1;
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            tx_d = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d = 5'd0;
                        tx_done_d  = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Busy covers an accepted write, queued bytes and a frame on the line,
    // registered so it drops the cycle after the final tx_done.
    always_comb begin
        busy_d = (state_q != IDLE) || (fifo_count_s != {CNT_W{1'b0}}) || (wr && !full);
    end

    // Serialiser registers; the line returns high on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= 5'd0;
            bit_cnt_q  <= {BIT_W{1'b0}};
            shift_q    <= {DATA_BITS{1'b0}};
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: an independent serial receiver model decodes
// the line and checks each frame against a queue of expected bytes.
module tb_uart_transmitter;

    logic       clk, reset, tick, wr, full, busy, tx, tx_done;
    logic [7:0] din;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned tick_per = 4;
    bit          tick_en  = 1'b0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];

    uart_transmitter #(
        .DATA_BITS  (8),
        .STOP_TICKS (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .din     (din),
        .wr      (wr),
        .full    (full),
        .busy    (busy),
        .tx      (tx),
        .tx_done (tx_done)
    );

    // Clock plus tick generator: tick is high at posedges numbered multiple of tick_per.
    initial begin
        clk  = 1'b0;
        tick = 1'b0;
        forever begin
            #5 clk = 1'b1;
            cyc++;
            #5 clk = 1'b0;
            tick = tick_en && (((cyc + 1) % tick_per) == 0);
        end
    end

    // Total tx_done pulse counter.
    always @(posedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
    end

    // Receiver model: detect start, sample mid-bit, compare with scoreboard.
    int         m_state = 0;
    int         m_cnt   = 0;
    int         m_bits  = 0;
    logic [7:0] m_byte  = 8'h00;
    logic [7:0] m_exp;
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (tx === 1'b0) begin
                       m_state = 1;
                       m_cnt   = (tick === 1'b1) ? 1 : 0;
                   end
                1: begin
                       if (tick === 1'b1) m_cnt++;
                       if (m_cnt == 8) begin
                           n_checks++;
                           if (tx !== 1'b0) begin
                               n_fail++;
                               $display("FAIL rx_start_mid: tx=%b required 0", tx);
                           end
                           m_cnt = 0; m_bits = 0; m_state = 2;
                       end
                   end
                2: begin
                       if (tick === 1'b1) m_cnt++;
                       if (m_cnt == 16) begin
                           m_byte[m_bits] = tx;
                           m_bits++;
                           m_cnt = 0;
                           if (m_bits == 8) m_state = 3;
                       end
                   end
                default: begin
                       if (tick === 1'b1) m_cnt++;
                       if (m_cnt == 16) begin
                           n_checks++;
                           if (tx !== 1'b1) begin
                               n_fail++;
                               $display("FAIL rx_stop_bit: tx=%b required 1", tx);
                           end
                           n_checks++;
                           if (exp_q.size() == 0) begin
                               n_fail++;
                               $display("FAIL rx_unexpected_frame: got 0x%02h, none expected", m_byte);
                           end else begin
                               m_exp = exp_q.pop_front();
                               if (m_byte !== m_exp) begin
                                   n_fail++;
                                   $display("FAIL rx_byte: got 0x%02h required 0x%02h", m_byte, m_exp);
                               end
                           end
                           m_state = 0;
                       end
                   end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int seen = 0;
        int i    = 0;
        while (seen < n && i < budget) begin
            step();
            if (tx_done === 1'b1) seen++;
            i++;
        end
        n_checks++;
        if (seen != n) begin
            n_fail++;
            $display("FAIL %s: saw %0d tx_done pulses, required %0d", name, seen, n);
        end
    endtask

    task automatic wait_fall(input string name);
        int i = 0;
        while (tx !== 1'b0 && i < 10) begin
            step();
            i++;
        end
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: start bit not seen, tx=%b", name, tx);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = 1'b0; din = 8'h00; tick_en = 1'b0;
        repeat (3) step();
        n_checks++; if (tx !== 1'b1)      begin n_fail++; $display("FAIL reset_tx: %b required 1", tx); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: %b required 0", busy); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done: %b required 0", tx_done); end
        n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full: %b required 0", full); end
        reset = 1'b0;
        repeat (3) step();
        n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: tx=%b busy=%b required 1/0", tx, busy);
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] pattern;
        logic [7:0] b;
        int         early_done = 0;
        b = 8'hA5;
        pattern = {1'b1, b, 1'b0};
        tick_per = 4; tick_en = 1'b1;
        do step(); while (((cyc + 2) % 4) != 0);
        din = b; wr = 1'b1; exp_q.push_back(b);
        step();
        wr = 1'b0;
        n_checks++; if (busy !== 1'b1 || tx !== 1'b1) begin
            n_fail++; $display("FAIL single_busy_rise: busy=%b tx=%b required 1/1", busy, tx);
        end
        step();
        for (int j = 0; j < 640; j++) begin
            if (j > 0) step();
            n_checks++;
            if (tx !== pattern[j / 64]) begin
                n_fail++;
                $display("FAIL single_line: clk %0d of frame tx=%b required %b", j, tx, pattern[j / 64]);
            end
            if (tx_done === 1'b1) early_done++;
        end
        n_checks++; if (early_done != 0) begin n_fail++; $display("FAIL single_early_done: %0d pulses required 0", early_done); end
        step();
        n_checks++; if (tx_done !== 1'b1 || tx !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_end: tx_done=%b tx=%b busy=%b required 1/1/1", tx_done, tx, busy);
        end
        step();
        n_checks++; if (tx_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_after: tx_done=%b busy=%b required 0/0", tx_done, busy);
        end
        repeat (20) step();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_pending: %0d bytes left", exp_q.size()); end
    endtask

    task automatic test_fifo_fill();
        tick_en = 1'b0;
        repeat (2) step();
        for (int i = 1; i <= 6; i++) begin
            din = 8'(i); wr = 1'b1;
            if (i <= 5) exp_q.push_back(8'(i));
            step();
            n_checks++;
            if (full !== (i >= 5)) begin
                n_fail++; $display("FAIL fill_full after 0x%02h: %b required %b", i, full, (i >= 5));
            end
        end
        wr = 1'b0;
        n_checks++; if (dut.u_fifo.count_q !== 3'd4) begin
            n_fail++; $display("FAIL fill_count: %0d required 4", dut.u_fifo.count_q);
        end
        tick_per = 2; tick_en = 1'b1;
        wait_done(5, 4000, "fill_frames");
        repeat (40) step();
        n_checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL fill_drain: %0d left busy=%b required 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int start_cnt, seen, i;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C; bytes[3] = 8'h80;
        tick_per = 2; tick_en = 1'b1;
        start_cnt = done_cnt;
        for (int k = 0; k < 4; k++) begin
            din = bytes[k]; wr = 1'b1; exp_q.push_back(bytes[k]);
            step();
        end
        wr = 1'b0;
        seen = 0; i = 0;
        while (seen < 4 && i < 3000) begin
            step(); i++;
            if (tx_done === 1'b1) begin
                seen++;
                if (seen < 4) begin
                    step(); i++;
                    n_checks++;
                    if (tx !== 1'b0) begin n_fail++; $display("FAIL b2b_next_start: tx=%b required 0", tx); end
                end
            end
        end
        repeat (10) step();
        n_checks++; if (done_cnt - start_cnt != 4) begin
            n_fail++; $display("FAIL b2b_done_count: %0d required 4", done_cnt - start_cnt);
        end
        n_checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: %0d left busy=%b", exp_q.size(), busy);
        end
    endtask

    task automatic test_stall();
        int ticks = 0;
        int i;
        logic t;
        tick_per = 4; tick_en = 1'b1;
        din = 8'h3D; wr = 1'b1; exp_q.push_back(8'h3D);
        step();
        wr = 1'b0;
        wait_fall("stall_fall");
        for (i = 0; i < 400; i++) begin
            if (i == 20)  tick_en = 1'b0;
            if (i == 120) tick_en = 1'b1;
            @(negedge clk); #1; t = tick;
            step();
            if (t === 1'b1) ticks++;
            if (i >= 20 && i < 120) begin
                n_checks++;
                if (tx !== 1'b0) begin n_fail++; $display("FAIL stall_hold: tx=%b required 0 at %0d", tx, i); end
            end
            if (tx === 1'b1) break;
        end
        n_checks++; if (ticks != 16) begin n_fail++; $display("FAIL stall_ticks: start bit %0d ticks required 16", ticks); end
        n_checks++; if (i < 120) begin n_fail++; $display("FAIL stall_len: start bit ended at %0d clk, required >= 120", i); end
        wait_done(1, 2000, "stall_done");
        repeat (10) step();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_pending: %0d left", exp_q.size()); end
    endtask

    task automatic test_corner_full_pop();
        int i = 0;
        tick_en = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 5; k++) begin
            din = 8'h11 * 8'(k + 1); wr = 1'b1; exp_q.push_back(8'h11 * 8'(k + 1));
            step();
        end
        wr = 1'b0;
        tick_per = 1; tick_en = 1'b1;
        while (tx_done !== 1'b1 && i < 400) begin step(); i++; end
        n_checks++; if (tx_done !== 1'b1 || full !== 1'b1) begin
            n_fail++; $display("FAIL corner_setup: tx_done=%b full=%b required 1/1", tx_done, full);
        end
        din = 8'hEE; wr = 1'b1;
        step();
        wr = 1'b0;
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL corner_full: %b required 0", full); end
        n_checks++; if (dut.u_fifo.count_q !== 3'd3) begin
            n_fail++; $display("FAIL corner_count: %0d required 3", dut.u_fifo.count_q);
        end
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL corner_next_start: tx=%b required 0", tx); end
        wait_done(4, 1200, "corner_frames");
        repeat (20) step();
        n_checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL corner_drain: %0d left busy=%b", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int start_cnt, lows = 0;
        tick_per = 1; tick_en = 1'b1;
        din = 8'h55; wr = 1'b1; exp_q.push_back(8'h55); step();
        din = 8'hAA; exp_q.push_back(8'hAA); step();
        din = 8'h0F; exp_q.push_back(8'h0F); step();
        wr = 1'b0;
        wait_fall("rst_fall");
        repeat (70) step();
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_bit3: tx=%b required 0", tx); end
        start_cnt = done_cnt;
        reset = 1'b1;
        step();
        exp_q.delete();
        n_checks++; if (tx !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: tx=%b full=%b busy=%b required 1/0/0", tx, full, busy);
        end
        reset = 1'b0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (tx !== 1'b1) lows++;
        end
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL rst_quiet: tx low for %0d clk required 0", lows); end
        n_checks++; if (done_cnt != start_cnt || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_frames: done delta %0d busy=%b required 0/0", done_cnt - start_cnt, busy);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Test sequence.
    initial begin
        reset = 1'b1; wr = 1'b0; din = 8'h00;
        test_reset();
        test_single_frame();
        test_fifo_fill();
        test_back_to_back();
        test_stall();
        test_corner_full_pop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
